// File: rtl/parity_stream_if.sv
// parity_stream_if: valid/ready stream link for parity_stream.
// Carries the input-side word/handshake and the output-side word/handshake.
// The slave modport is the parity_stream view; master is the producer/consumer view.
interface parity_stream_if #(
    parameter int DATA_W = 8
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_par;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W:0]   out_data;
    logic              out_err;

    modport master (
        output in_valid,
        output in_data,
        output in_par,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_err,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_par,
        output in_ready,
        output out_valid,
        output out_data,
        output out_err,
        input  out_ready
    );

endinterface

// File: rtl/parity_stream.sv
// parity_stream: streaming parity generator/checker with a 2-entry output buffer.
// Generate mode appends p = ^data ^ odd as the MSB; check mode keeps the received
// parity bit, flags mismatches and keeps a saturating error count.
// Optional feature macro: PARITY_ERR_INJECT_EN (adds inj_err, inverts computed parity).
module parity_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    parity_stream_if.slave   s,
    input  logic             mode_check,
    input  logic             odd,
    input  logic             clr_err,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err_sticky
`ifdef PARITY_ERR_INJECT_EN
    ,
    input  logic             inj_err
`endif
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    typedef struct packed {
        logic            err;
        logic [DATA_W:0] word;
    } entry_t;

    occ_e             occ_q, occ_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic             alive_q, alive_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_sticky_q, err_sticky_d;

    logic             inj;
    logic             in_ready_w;
    logic             out_valid_w;
    logic             push;
    logic             pop;
    logic             p_calc;
    entry_t           new_ent;
    logic [CNT_W-1:0] cnt_base;
    logic             sticky_base;

    // Injection source: tied off when the feature is compiled out.
    always_comb begin
`ifdef PARITY_ERR_INJECT_EN
        inj = inj_err;
`else
        inj = 1'b0;
`endif
    end

    // Handshake qualifiers from registered state only (no out_ready -> in_ready path).
    always_comb begin
        in_ready_w  = alive_q & (occ_q != OCC_TWO);
        out_valid_w = (occ_q != OCC_EMPTY);
        push        = s.in_valid & in_ready_w;
        pop         = out_valid_w & s.out_ready;
    end

    // Build the entry for an accepted word; injection just flips the computed parity,
    // which covers both the generate-mode inversion and the forced check-mode error.
    always_comb begin
        p_calc       = (^s.in_data) ^ odd ^ inj;
        new_ent      = '0;
        new_ent.word = {(mode_check ? s.in_par : p_calc), s.in_data};
        new_ent.err  = mode_check & (s.in_par != p_calc);
    end

    // Buffer next state: head is always the word presented on the output.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    head_d = new_ent;
                    occ_d  = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    head_d = new_ent;
                end else if (push) begin
                    tail_d = new_ent;
                    occ_d  = OCC_TWO;
                end else if (pop) begin
                    occ_d  = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    head_d = tail_q;
                    occ_d  = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    // Input readiness comes up on the first edge after reset release.
    always_comb begin
        alive_d = 1'b1;
    end

    // Error bookkeeping: a coincident clear is applied before the new error counts.
    always_comb begin
        cnt_base     = clr_err ? '0   : err_cnt_q;
        sticky_base  = clr_err ? 1'b0 : err_sticky_q;
        err_cnt_d    = cnt_base;
        err_sticky_d = sticky_base;
        if (push && new_ent.err) begin
            err_sticky_d = 1'b1;
            if (cnt_base != '1) begin
                err_cnt_d = cnt_base + CNT_W'(1);
            end
        end
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q        <= OCC_EMPTY;
            head_q       <= '0;
            tail_q       <= '0;
            alive_q      <= 1'b0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            occ_q        <= occ_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            alive_q      <= alive_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Output drive.
    always_comb begin
        s.in_ready  = in_ready_w;
        s.out_valid = out_valid_w;
        s.out_data  = head_q.word;
        s.out_err   = head_q.err;
        err_cnt     = err_cnt_q;
        err_sticky  = err_sticky_q;
    end

endmodule

// File: doc/parity_stream.md
Name: parity_stream

Overview:
- Parametrised streaming successor to the fixed 8-bit combinational parity generator.
- Generate mode: appends an even/odd parity bit to each DATA_W-bit word.
- Check mode: verifies a received parity bit, flags mismatches and keeps a saturating error count.
- Sits between a producer and consumer on valid/ready links; a 2-entry output buffer gives full throughput under backpressure.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- CNT_W, 8, error counter width (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mode_check  in  1  0 = generate, 1 = check; sampled per accepted word.
- odd  in  1  0 = even parity, 1 = odd parity; sampled per accepted word.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  payload.
- in_par  in  1  received parity bit; used in check mode only.
- out_valid  out  1  output word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  DATA_W+1  {parity, payload}; parity in the MSB.
- out_err  out  1  parity mismatch on the current output word (check mode only).
- err_cnt  out  CNT_W  saturating count of mismatching accepted words.
- err_sticky  out  1  set on any mismatch, held until cleared.
- clr_err  in  1  synchronous clear of err_cnt and err_sticky.

Behaviour:
- Reset (async, any time): buffer emptied; in_ready=1 on the first edge after reset deassertion (0 while rst high); out_valid=0, out_data=0, out_err=0, err_cnt=0, err_sticky=0. A word in flight when reset asserts is dropped.
- Handshakes:
  - Input transfer on an edge with in_valid & in_ready.
  - Output transfer on an edge with out_valid & out_ready.
  - out_valid, out_data and out_err stay stable while out_valid & !out_ready.
- Parity computation: p = (XOR of all in_data bits) XOR odd, evaluated at input acceptance.
- Generate mode: stored word = {p, in_data}; out_err=0.
- Check mode: stored word = {in_par, in_data}; out_err = (in_par != p).
- Buffer: 2-entry FIFO, order preserved.
  - in_ready = (occupancy < 2), derived from registered occupancy only; no combinational path from out_ready.
  - Simultaneous push and pop at occupancy 2 is not allowed (in_ready=0).
  - Simultaneous push and pop at occupancy 1 keeps occupancy 1.
- Latency: a word accepted at edge k appears with out_valid=1 after edge k when the buffer was empty. Throughput: 1 word/cycle with out_ready held high.
- Error counter:
  - Increments at acceptance of a check-mode mismatching word.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - err_sticky sets on the same event.
- clr_err concurrent with a mismatching acceptance: clear applies first, then the new error counts, giving err_cnt=1 and err_sticky=1.
- Changing mode_check or odd mid-stream affects only words accepted afterwards.

Optional Feature:
- Macro: PARITY_ERR_INJECT_EN.
- Defined:
  - Extra input port inj_err (1 bit).
  - In generate mode, a word accepted while inj_err=1 has its parity bit inverted. Used for downstream checker testing.
  - In check mode, inj_err inverts the computed p, forcing out_err=1 for a correct word; the error is counted.
- Undefined: port absent; behaviour exactly as specified above.

Test Plan:
- DATA_W=8, generate, even, out_ready=1; in_data 8'h00, 8'h01, 8'h07, 8'h03 back-to-back -> out_data 9'h000, 9'h101, 9'h107, 9'h003 on consecutive cycles; out_err=0; err_cnt=0.
- Generate, odd=1; in_data 8'h00, 8'h01 -> out_data 9'h100, 9'h001.
- Check, even; in_data 8'h01 with in_par=0 -> out_err=1, err_cnt=1, err_sticky=1; then in_data 8'h01 with in_par=1 -> out_err=0, err_cnt stays 1.
- Backpressure: out_ready=0, offer 3 words 8'hA1, 8'hA2, 8'hA3 -> two accepted, in_ready=0, third held; raise out_ready -> outputs emerge in order A1, A2, A3 with no loss or duplication; out_data stable while stalled.
- CNT_W=2: 5 mismatching words -> err_cnt sticks at 3; then clr_err coincident with a mismatching acceptance -> err_cnt=1, err_sticky=1; clr_err alone -> both 0.
- Async reset asserted between clock edges with 2 words buffered -> out_valid, err_cnt and err_sticky drop to 0 immediately without waiting for an edge; after release, in_ready=1 and the first new word has 1-cycle latency.
